// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the wait-state external data memory.
// Used by ext_mem_ws and ext_mem_array.
package ext_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ext_mem_state_t;

    localparam int LAT_CNT_W = 4;

    typedef struct packed {
        logic [7:0] width;
        logic [7:0] offset;
    } idx_geom_t;

    // Word-index width and its bit offset inside the byte address.
    function automatic idx_geom_t index_w(input int depth, input int be_w);
        idx_geom_t g;
        g.width  = 8'($clog2(depth));
        g.offset = 8'($clog2(be_w));
        return g;
    endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Byte-writable synchronous word storage with read-before-write.
// A killed access writes nothing and returns zero.
module ext_mem_array
    import ext_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = 12,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access,
    input  logic              kill,
    input  logic              write,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage update: only enabled byte lanes are written; contents are never reset.
    always_ff @(posedge clk) begin
        if (access && write && !kill) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be[k]) begin
                    mem[index][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Read register samples the old word on the same edge as the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (access) begin
            rdata <= kill ? '0 : mem[index];
        end
    end

endmodule

// File: rtl/ext_mem_ws.sv
// Parametrised external data memory with configurable wait states for the LSU bus.
// Optional range checking with err_o is enabled by defining EXT_MEM_RANGE_CHK_EN.
module ext_mem_ws
    import ext_mem_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 4096,
    parameter  int LATENCY = 0,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_i,
    input  logic              write_enable_i,
    input  logic [BE_W-1:0]   byte_enable_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] write_data_i,
    output logic [DATA_W-1:0] read_data_o,
    output logic              ready_o
`ifdef EXT_MEM_RANGE_CHK_EN
    ,
    output logic              err_o
`endif
);

    localparam idx_geom_t GEOM = index_w(DEPTH, BE_W);
    localparam int IDX_W = int'(GEOM.width);
    localparam int OFF_W = int'(GEOM.offset);
    localparam logic [LAT_CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : LAT_CNT_W'(LATENCY - 1);

    ext_mem_state_t state, state_nxt;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 accept;
    logic                 complete;
    logic                 kill;

    logic [IDX_W-1:0]  idx_q, acc_idx;
    logic              we_q, acc_we;
    logic [BE_W-1:0]   be_q, acc_be;
    logic [DATA_W-1:0] wdata_q, acc_wdata;

    // Next-state logic; complete marks the edge that enters RESP.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                        complete  = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    complete  = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero latency the access completes on its acceptance edge, so live inputs are used.
    always_comb begin
        if (state == IDLE) begin
            acc_idx   = addr_i[OFF_W +: IDX_W];
            acc_we    = write_enable_i;
            acc_be    = byte_enable_i;
            acc_wdata = write_data_i;
        end else begin
            acc_idx   = idx_q;
            acc_we    = we_q;
            acc_be    = be_q;
            acc_wdata = wdata_q;
        end
    end

`ifdef EXT_MEM_RANGE_CHK_EN
    localparam logic [31:0] HI_MASK = ~((32'd1 << (OFF_W + IDX_W)) - 32'd1);
    logic oor_q;

    // Out-of-range flag follows the same live/latched selection as the operands.
    always_comb begin
        if (state == IDLE) begin
            kill = |(addr_i & HI_MASK);
        end else begin
            kill = oor_q;
        end
    end

    // Range-error latch and response flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oor_q <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (accept) begin
                oor_q <= kill;
            end
            err_o <= complete & kill;
        end
    end
`else
    assign kill = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^addr_i;

    // FSM state, wait counter and completion pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_o <= complete;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Request latch; later input changes are ignored until the next acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            idx_q   <= addr_i[OFF_W +: IDX_W];
            we_q    <= write_enable_i;
            be_q    <= byte_enable_i;
            wdata_q <= write_data_i;
        end
    end

    ext_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .BE_W   (BE_W)
    ) u_array (
        .clk    (clk_i),
        .rst    (rst_i),
        .access (complete),
        .kill   (kill),
        .write  (acc_we),
        .be     (acc_be),
        .index  (acc_idx),
        .wdata  (acc_wdata),
        .rdata  (read_data_o)
    );

endmodule

// File: tb/tb_ext_mem_ws.sv
// Self-checking bench for ext_mem_ws: a zero-latency and a three-wait-state instance
// share stimulus; expected read data flows through a scoreboard queue.
module tb_ext_mem_ws;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3;
    logic        err0, err3;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic        chk_q[$];
    logic        err_q[$];

    always #5 clk = ~clk;

    ext_mem_ws #(.DATA_W(32), .DEPTH(4096), .LATENCY(0)) u_l0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req0), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wdata),
        .read_data_o(rd0), .ready_o(rdy0)
`ifdef EXT_MEM_RANGE_CHK_EN
        , .err_o(err0)
`endif
    );

    ext_mem_ws #(.DATA_W(32), .DEPTH(4096), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req3), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wdata),
        .read_data_o(rd3), .ready_o(rdy3)
`ifdef EXT_MEM_RANGE_CHK_EN
        , .err_o(err3)
`endif
    );

`ifndef EXT_MEM_RANGE_CHK_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    typedef struct {
        int          sel;
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
        logic        chk;
        logic        e_err;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input int sel, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] e, input logic chk, input logic e_err);
        vec_t v;
        v.sel = sel; v.w = w; v.b = b; v.a = a; v.d = d; v.e = e; v.chk = chk; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic access(input int sel, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                          input logic chk, input logic e_err, input logic perturb);
        int          lat;
        int          n;
        logic        got;
        logic [31:0] exp_rd;
        logic        exp_chk;
        logic        exp_err;
        lat = (sel == 0) ? 0 : 3;
        @(negedge clk);
        we = w; be = b; addr = a; wdata = d;
        if (sel == 0) req0 = 1'b1; else req3 = 1'b1;
        exp_q.push_back(e); chk_q.push_back(chk); err_q.push_back(e_err);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            if (perturb && n == 0) begin
                addr  = a ^ 32'h30;
                wdata = ~d;
            end
            if ((sel == 0) ? rdy0 : rdy3) got = 1'b1; else n++;
        end
        req0 = 1'b0; req3 = 1'b0;
        exp_rd = exp_q.pop_front(); exp_chk = chk_q.pop_front(); exp_err = err_q.pop_front();
        if (!got) begin
            check("ready_timeout", 32'(n), 32'(lat));
        end else begin
            check("latency", 32'(n), 32'(lat));
            if (exp_chk) check("read_data", (sel == 0) ? rd0 : rd3, exp_rd);
`ifdef EXT_MEM_RANGE_CHK_EN
            check("err", 32'((sel == 0) ? err0 : err3), 32'(exp_err));
`endif
            @(posedge clk); #1;
            check("ready_pulse_end", 32'((sel == 0) ? rdy0 : rdy3), 32'd0);
            if (exp_chk) check("read_data_held", (sel == 0) ? rd0 : rd3, exp_rd);
        end
    endtask

    initial begin
        int pulses[$];
        int hits;

        vecs[0]  = mk(0, 1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
        vecs[1]  = mk(0, 1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
        vecs[2]  = mk(0, 1'b1, 4'hF, 32'h40,   32'h11223344, 32'h0,        1'b0, 1'b0);
        vecs[3]  = mk(0, 1'b1, 4'hA, 32'h40,   32'hAABBCCDD, 32'h11223344, 1'b1, 1'b0);
        vecs[4]  = mk(0, 1'b0, 4'h0, 32'h40,   32'h0,        32'hAA22CC44, 1'b1, 1'b0);
        vecs[5]  = mk(0, 1'b1, 4'h0, 32'h40,   32'hFFFFFFFF, 32'hAA22CC44, 1'b1, 1'b0);
        vecs[6]  = mk(0, 1'b0, 4'h0, 32'h43,   32'h0,        32'hAA22CC44, 1'b1, 1'b0);
        vecs[7]  = mk(0, 1'b1, 4'h5, 32'h40,   32'h00FF00FF, 32'hAA22CC44, 1'b1, 1'b0);
        vecs[8]  = mk(0, 1'b0, 4'h0, 32'h40,   32'h0,        32'hAAFFCCFF, 1'b1, 1'b0);
`ifdef EXT_MEM_RANGE_CHK_EN
        vecs[9]  = mk(0, 1'b1, 4'hF, 32'h4010, 32'hCAFEF00D, 32'h0,        1'b1, 1'b1);
        vecs[10] = mk(0, 1'b0, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
`else
        vecs[9]  = mk(0, 1'b1, 4'hF, 32'h4010, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 1'b0);
        vecs[10] = mk(0, 1'b0, 4'h0, 32'h10,   32'h0,        32'hCAFEF00D, 1'b1, 1'b0);
`endif
        vecs[11] = mk(3, 1'b1, 4'hF, 32'h80,   32'h12345678, 32'h0,        1'b0, 1'b0);
        vecs[12] = mk(3, 1'b0, 4'h0, 32'h80,   32'h0,        32'h12345678, 1'b1, 1'b0);
        vecs[13] = mk(3, 1'b1, 4'hC, 32'h80,   32'hABCD0000, 32'h12345678, 1'b1, 1'b0);
        vecs[14] = mk(3, 1'b0, 4'h0, 32'h80,   32'h0,        32'hABCD5678, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready0", 32'(rdy0), 32'd0);
        check("reset_rdata0", rd0, 32'd0);
        check("reset_ready3", 32'(rdy3), 32'd0);
        check("reset_rdata3", rd3, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            access(vecs[i].sel, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d,
                   vecs[i].e, vecs[i].chk, vecs[i].e_err, 1'b0);
        end

        // Held request: pulses every LATENCY+2 cycles, each one cycle wide.
        @(negedge clk);
        we = 1'b0; be = 4'h0; addr = 32'h80; req3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (rdy3) begin
                pulses.push_back(k);
                check("held_read_data", rd3, 32'hABCD5678);
            end
        end
        req3 = 1'b0;
        check("held_pulse_count", 32'(pulses.size()), 32'd2);
        if (pulses.size() == 2) begin
            check("held_first_pulse", 32'(pulses[0]), 32'd3);
            check("held_second_pulse", 32'(pulses[1]), 32'd8);
        end
        repeat (4) @(posedge clk);

        // Reset during WAIT abandons the write.
        @(negedge clk);
        we = 1'b1; be = 4'hF; addr = 32'h80; wdata = 32'h0; req3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req3 = 1'b0;
        #1;
        check("midreset_rdata", rd3, 32'd0);
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rdy3) hits++;
        end
        check("midreset_no_ready", 32'(hits), 32'd0);
        access(3, 1'b0, 4'h0, 32'h80, 32'h0, 32'hABCD5678, 1'b1, 1'b0, 1'b0);

        // Inputs changed during WAIT must not affect the latched access.
        access(3, 1'b1, 4'hF, 32'h90, 32'h55555555, 32'h0, 1'b0, 1'b0, 1'b0);
        access(3, 1'b1, 4'hF, 32'hA0, 32'h11111111, 32'h0, 1'b0, 1'b0, 1'b1);
        access(3, 1'b0, 4'h0, 32'hA0, 32'h0, 32'h11111111, 1'b1, 1'b0, 1'b0);
        access(3, 1'b0, 4'h0, 32'h90, 32'h0, 32'h55555555, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ext_mem_ws.md
Name: ext_mem_ws

Overview:
Parametrised external data memory for the LSU bus. It is the successor to the fixed 32-bit, 4096-word, always-ready data RAM.
- Adds configurable data width, depth and wait-state latency.
- Supports arbitrary byte-enable masks.
- Uses a real one-cycle ready_o completion pulse, so the LSU stall logic can be exercised.
- Sits behind the LSU and serves one outstanding access at a time.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8
DEPTH, 4096, number of words; power of two
LATENCY, 0, extra wait cycles per access (0..15); 0 gives legacy single-cycle timing
BE_W, DATA_W/8, byte-enable width (derived, not overridden)

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  asynchronous, active-high reset
mem_req_i  in  1  access request; held by requester until ready_o
write_enable_i  in  1  1 = write, 0 = read
byte_enable_i  in  BE_W  per-byte write mask; bit k covers bits [8k+7:8k]
addr_i  in  32  byte address; word index = addr_i[$clog2(BE_W) +: $clog2(DEPTH)]
write_data_i  in  DATA_W  write data
read_data_o  out  DATA_W  read data; valid while ready_o=1, held afterwards
ready_o  out  1  one-cycle completion pulse
err_o  out  1  only with EXT_MEM_RANGE_CHK_EN (see Optional Feature)

Behaviour:
- Reset (async, on rst_i high): state=IDLE, ready_o=0, read_data_o=0, wait counter=0. Memory contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On mem_req_i=1, latch addr, we, be and wdata.
  - If LATENCY=0, go to RESP; otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle; on counter=0, go to RESP.
- Completion edge (the edge that enters RESP):
  - Read the word at the latched index into read_data_o. The read is always performed, even for writes, and returns the pre-write contents (read-before-write).
  - If latched we=1, update only the bytes whose be bit is set. be=0 writes nothing. All 2^BE_W masks are legal, including non-contiguous ones.
- RESP: ready_o=1 for exactly this cycle; next state is always IDLE. A request present in RESP is not accepted; it is accepted in the following IDLE cycle.
- Latency: ready_o asserts LATENCY+1 cycles after the acceptance edge. Maximum throughput is one access per LATENCY+2 cycles.
- Inputs changing after acceptance have no effect; the latched values are used.
- ready_o is never high in IDLE or WAIT.
- Address bits above the index are ignored, so accesses wrap modulo DEPTH words. Low byte-offset bits are ignored.
- Reset mid-access: the access is abandoned, no write is performed and no ready_o is issued.

Optional Feature:
Macro EXT_MEM_RANGE_CHK_EN.
- Defined:
  - err_o port exists; it is reset to 0 and asserted together with ready_o when any latched address bit above the index field is nonzero.
  - For such an access the write is suppressed and read_data_o=0.
- Undefined: err_o is absent and out-of-range addresses wrap as described above.

Decomposition:
- Package ext_mem_pkg holds:
  - state enum typedef ext_mem_state_t {IDLE, WAIT, RESP};
  - LAT_CNT_W=4;
  - function index_w(DEPTH, BE_W) returning the index width and offset.
- Sub-module ext_mem_array holds the byte-writable synchronous storage with per-byte write enables and read-before-write. The top module holds the FSM, request latch and counter.

Test Plan:
1. LATENCY=0: write 0xDEADBEEF, be=4'hF, addr 0x10; then read addr 0x10 -> ready_o one cycle after each acceptance, read_data_o=0xDEADBEEF.
2. LATENCY=3: read with mem_req_i held -> ready_o high exactly 4 cycles after acceptance, for one cycle only; next access accepted no earlier than cycle 5.
3. Byte masks: preload 0x11223344, write 0xAABBCCDD with be=4'b1010 -> readback 0xAA22CC44; a write with be=0 leaves the word unchanged.
4. Wrap: DEPTH=4096, write addr 0x4010 -> readback at addr 0x0010 returns the same data. With EXT_MEM_RANGE_CHK_EN, err_o=1 on that write, read_data_o=0 and word 0x0010 is unchanged.
5. Reset mid-WAIT (LATENCY=5, write issued, rst_i pulsed at cycle 2) -> ready_o stays 0, the target word is unchanged, and the FSM is in IDLE after release.
6. Input change: alter addr_i and write_data_i during WAIT -> the latched address and data are used.
